// File: rtl/sc_stream_engine.sv
// Stochastic-computing engine: one LFSR feeds two comparator SNGs whose streams are combined
// per mode and counted back to binary over a LEN-cycle window, with a start/done handshake.
module sc_stream_engine #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 'h2D,
  parameter logic [WIDTH-1:0] SEED = 'h01,
  parameter int unsigned     LEN   = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             bit_out_o,
  output logic             bit_valid_o
);

  // An all-zero LFSR never leaves zero, so a zero seed is promoted to 1.
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SeedEff = (SEED == '0) ? One : SEED;
  localparam logic [WIDTH-1:0] LenM1   = WIDTH'(LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] ones_q, ones_d;
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;

  logic [WIDTH-1:0] lfsr_rev;
  logic [WIDTH-1:0] lfsr_step;
  logic             sa, sb, out_bit;

  // Bit-reversed tap decorrelates the B stream from the A stream.
  always_comb begin
    lfsr_rev = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      lfsr_rev[i] = lfsr_q[WIDTH-1-i];
    end
  end

  assign lfsr_step = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};
  assign sa        = (lfsr_q < a_q);
  assign sb        = (lfsr_rev < b_q);

  always_comb begin
    out_bit = 1'b0;
    unique case (mode_q)
      2'd0:    out_bit = sa & sb;
      2'd1:    out_bit = sa | sb;
      2'd2:    out_bit = sa ^ sb;
      default: out_bit = sa;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    lfsr_d      = lfsr_q;
    ones_d      = ones_q;
    cyc_d       = cyc_q;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bit_out_d   = bit_out_q;
    bit_valid_d = bit_valid_q;
    unique case (state_q)
      StIdle: begin
        bit_valid_d = 1'b0;
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          mode_d  = mode_i;
          lfsr_d  = SeedEff;
          ones_d  = '0;
          cyc_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        ones_d      = ones_q + {{(WIDTH-1){1'b0}}, out_bit};
        bit_out_d   = out_bit;
        bit_valid_d = 1'b1;
        lfsr_d      = lfsr_step;
        cyc_d       = cyc_q + One;
        if (cyc_q == LenM1) begin
          state_d = StFin;
        end
      end
      StFin: begin
        // Last stream bit is on bit_out this cycle; publish the count on the next edge.
        result_d    = ones_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        bit_valid_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 2'd0;
      lfsr_q      <= SeedEff;
      ones_q      <= '0;
      cyc_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      lfsr_q      <= lfsr_d;
      ones_q      <= ones_d;
      cyc_q       <= cyc_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign bit_out_o   = bit_out_q;
  assign bit_valid_o = bit_valid_q;

endmodule

// File: tb/tb_sc_stream_engine.sv
// Directed and model-swept bench for sc_stream_engine (WIDTH=8, TAPS=2D, SEED=1, LEN=255).
module tb_sc_stream_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       busy, done, bit_out, bit_valid;
  logic [7:0] result;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sc_stream_engine #(
    .WIDTH(8),
    .TAPS (8'h2D),
    .SEED (8'h01),
    .LEN  (255)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .mode_i     (mode),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .bit_out_o  (bit_out),
    .bit_valid_o(bit_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Reference: walk the full 255-step LFSR sequence from the seed and count output ones.
  function automatic logic [7:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic [1:0] mv);
    logic [7:0] l;
    logic       sa, sb, o;
    int         ones;
    l    = 8'h01;
    ones = 0;
    for (int i = 0; i < 255; i++) begin
      sa = (l < av);
      sb = (rev8(l) < bv);
      case (mv)
        2'd0:    o = sa & sb;
        2'd1:    o = sa | sb;
        2'd2:    o = sa ^ sb;
        default: o = sa;
      endcase
      ones += int'(o);
      l = {^(l & 8'h2D), l[7:1]};
    end
    return 8'(ones);
  endfunction

  // Runs one window; returns in the done cycle (sampled #1 after the done edge).
  // b2b=1 raises start immediately (caller is in a done cycle). p1/p2: extra start pulses.
  task automatic run_win(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] mv,
                         input bit b2b, input int p1, input int p2, input logic [7:0] exp_res,
                         input string tag);
    int lat;
    int vcnt;
    if (!b2b) @(negedge clk);
    a     = av;
    b     = bv;
    mode  = mv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    // Scramble live inputs; the engine must use its latched copies.
    a    = ~av;
    b    = ~bv;
    mode = mv + 2'd1;
    lat  = 0;
    vcnt = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (bit_valid) vcnt++;
      start = (lat == p1 || lat == p2);
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd256);
    check({tag, "_valid_cycles"}, 32'(vcnt), 32'd255);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
  endtask

  task automatic check_done_drops(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] rm;
    int         seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_bitout", 32'(bit_out), 32'd0);
    check("rst_bitvalid", 32'(bit_valid), 32'd0);
    rst = 1'b0;

    // Pass-A self-check
    run_win(8'd128, 8'd0, 2'd3, 1'b0, -1, -1, 8'd127, "pass128");
    check_done_drops("pass128");
    run_win(8'd0, 8'd99, 2'd3, 1'b0, -1, -1, 8'd0, "pass0");
    run_win(8'd255, 8'd0, 2'd3, 1'b0, -1, -1, 8'd254, "pass255");
    check_done_drops("pass255");

    // AND / XOR / OR
    run_win(8'd255, 8'd255, 2'd0, 1'b0, -1, -1, 8'd254, "and_ff");
    run_win(8'd0, 8'd200, 2'd0, 1'b0, -1, -1, 8'd0, "and_0");
    run_win(8'd77, 8'd77, 2'd2, 1'b0, -1, -1, model(8'd77, 8'd77, 2'd2), "xor77");
    run_win(8'd255, 8'd0, 2'd1, 1'b0, -1, -1, 8'd254, "or_ff");

    // Starts while busy are ignored; then a back-to-back start from the done cycle
    run_win(8'd128, 8'd0, 2'd3, 1'b0, 10, 100, 8'd127, "ignore");
    run_win(8'd0, 8'd0, 2'd3, 1'b1, -1, -1, 8'd0, "b2b");
    check_done_drops("b2b");

    // Reset mid-window after a nonzero result
    run_win(8'd200, 8'd0, 2'd3, 1'b0, -1, -1, model(8'd200, 8'd0, 2'd3), "pre_rst");
    @(negedge clk);
    a     = 8'd50;
    mode  = 2'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_bitvalid", 32'(bit_valid), 32'd0);
    check("midrst_lfsr", 32'(dut.lfsr_q), 32'd1);
    seen = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    // Random sweep against the reference model
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 3));
      run_win(ra, rb, rm, 1'b0, -1, -1, model(ra, rb, rm), $sformatf("sweep%0d", i));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
